// File: rtl/autosel_i2c_pkg.sv
// Shared I2C definitions for the autosel controller and the EEPROM target model.
package autosel_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WORD,
    ST_ACK_WORD,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_state_t;

  // Level on SDA during the 9th clock of a byte.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Position of the R/W flag inside the address byte (1 = read).
  localparam int I2C_RW_BIT = 0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges and START/STOP events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  // [0],[1] form the 2-flop synchronizer; [2] holds the previous synced sample.
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_hold;

  // Shift the raw bus levels through the synchronizer and history flops.
  // NOTE: reset to 1 (idle bus level) so leaving reset never fakes a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // SCL high in both samples: an SDA edge here is a bus condition, while an
  // SDA edge coinciding with an SCL edge is treated as ordinary data.
  assign scl_hold = scl_q[1] & scl_q[2];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_hold & ~sda_q[1] & sda_q[2];
  assign stop     = scl_hold & sda_q[1] & ~sda_q[2];
  assign sda_s    = sda_q[1];

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a small 24Cxx EEPROM: word-address pointer,
// sequential writes and reads, no clock stretching.
module i2c_eeprom_target
  import autosel_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = 7'h50,
  parameter int         ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_state_t           state;
  logic [3:0]           bit_cnt;   // SCL rises seen in the current byte
  logic [7:0]           shift;     // receive shifter, or transmit byte
  logic [7:0]           rx_byte;   // shifter contents including the bit on SDA now
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           mem [DEPTH];
  logic                 rw;
  logic                 nack;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  assign sda_o   = 1'b0;
  assign rx_byte = {shift[6:0], sda_s};

  // Protocol FSM; owns the pointer, the memory array and every output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      nack      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      // NOTE: the array is reset on purpose -- it must read back 0x00 after
      // every reset, which a plain RAM macro would not guarantee.
      mem       <= '{default: '0};
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        // NOTE: the explicit default keeps unused encodings recoverable.
        case (state)
          ST_ADDR, ST_WORD, ST_WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && state == ST_WORD) begin
                ptr <= rx_byte[ADDR_BITS-1:0];
              end
              if (bit_cnt == 4'd7 && state == ST_WDATA) begin
                mem[ptr]  <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + ADDR_BITS'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ST_ADDR) begin
                if (shift[7:1] == I2C_ADDR) begin
                  state  <= ST_ACK_ADDR;
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                  rw     <= shift[I2C_RW_BIT];
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end else begin
                sda_oe <= 1'b1;
                state  <= (state == ST_WORD) ? ST_ACK_WORD : ST_ACK_WDATA;
              end
            end
          end
          ST_ACK_ADDR: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                state  <= ST_RDATA;
                shift  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
              end else begin
                state  <= ST_WORD;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_ACK_WORD, ST_ACK_WDATA: begin
            if (scl_fall) begin
              state   <= ST_WDATA;
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
            end
          end
          ST_RDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ptr <= ptr + ADDR_BITS'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state  <= ST_RACK;
              sda_oe <= 1'b0;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              shift  <= {shift[6:0], 1'b0};
              sda_oe <= ~shift[6];
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              nack <= (sda_s == I2C_NACK);
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (nack) begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end else begin
                state  <= ST_RDATA;
                shift  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
              end
            end
          end
          ST_IDLE, ST_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Self-checking bench for i2c_eeprom_target: bit-banged I2C controller plus
// an array model of the EEPROM contents and its address pointer.
module tb_i2c_eeprom_target;
  import autosel_i2c_pkg::*;

  localparam int AB    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [AB-1:0] a;
    logic [7:0]    d;
  } strobe_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          scl   = 1'b1;
  logic          m_low = 1'b0;
  logic          sda_bus;
  logic          sda_o, sda_oe, busy, wr_strobe;
  logic [AB-1:0] wr_addr;
  logic [7:0]    wr_data;

  int            tests = 0;
  int            failed = 0;
  int            oe_count = 0;
  strobe_t       strobe_q[$];
  logic [7:0]    tx_q[$];
  logic [7:0]    rd_q[$];
  logic [7:0]    model_mem [DEPTH];
  int            model_ptr = 0;

  // Open-drain wired-AND of the controller and the target.
  assign sda_bus = ~(m_low | sda_oe);

  i2c_eeprom_target #(.I2C_ADDR(7'h50), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Record every store pulse and every cycle the target pulls SDA low.
  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back('{wr_addr, wr_data});
    if (sda_oe) oe_count++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    m_low = 1'b0; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wait_q();
    scl   = 1'b1; wait_q(); wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    b     = sda_bus; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic ack);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(ack);
  endtask

  // Write transaction: word address then the bytes in tx_q.
  task automatic write_txn(input logic [7:0] word);
    int      base;
    logic    ack;
    strobe_t e;
    strobe_t exp_q[$];
    base = strobe_q.size();
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, I2C_ACK);
    check("wr_busy", busy, 1'b1);
    write_byte(word, ack);
    check("wr_word_ack", ack, I2C_ACK);
    model_ptr = int'(word) % DEPTH;
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      check($sformatf("wr_data_ack%0d", i), ack, I2C_ACK);
      e.a = AB'(model_ptr);
      e.d = tx_q[i];
      exp_q.push_back(e);
      model_mem[model_ptr] = tx_q[i];
      model_ptr = (model_ptr + 1) % DEPTH;
    end
    i2c_stop();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_strobe_count", strobe_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      if (base + i < strobe_q.size()) begin
        check($sformatf("wr_strobe_addr%0d", i), strobe_q[base+i].a, exp_q[i].a);
        check($sformatf("wr_strobe_data%0d", i), strobe_q[base+i].d, exp_q[i].d);
      end
    end
  endtask

  // Read transaction of n bytes; optional word-address phase plus repeated START.
  task automatic read_txn(input bit set_word, input logic [7:0] word, input int n);
    logic       ack;
    logic [7:0] b;
    rd_q.delete();
    i2c_start();
    if (set_word) begin
      write_byte(8'hA0, ack);
      check("rd_addr_w_ack", ack, I2C_ACK);
      write_byte(word, ack);
      check("rd_word_ack", ack, I2C_ACK);
      model_ptr = int'(word) % DEPTH;
      i2c_start();
    end
    write_byte(8'hA1, ack);
    check("rd_addr_r_ack", ack, I2C_ACK);
    for (int i = 0; i < n; i++) begin
      read_byte(b, (i == n - 1) ? I2C_NACK : I2C_ACK);
      check($sformatf("rd_data%0d", i), b, model_mem[model_ptr]);
      model_ptr = (model_ptr + 1) % DEPTH;
      rd_q.push_back(b);
    end
    check("rd_release_oe", sda_oe, 1'b0);
    check("rd_release_busy", busy, 1'b0);
    i2c_stop();
  endtask

  initial begin
    int         base;
    logic       ack;
    logic [7:0] addr_w;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    wait_q();
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wr_strobe", wr_strobe, 1'b0);
    check("reset_wr_addr", wr_addr, '0);
    check("reset_wr_data", wr_data, 8'h00);

    // Basic write of two bytes at word 3.
    base = strobe_q.size();
    tx_q.delete(); tx_q.push_back(8'h5A); tx_q.push_back(8'hC3);
    write_txn(8'h03);
    if (strobe_q.size() >= base + 2) begin
      check("w1_strobe0", {strobe_q[base].a, strobe_q[base].d}, {4'd3, 8'h5A});
      check("w1_strobe1", {strobe_q[base+1].a, strobe_q[base+1].d}, {4'd4, 8'hC3});
    end else begin
      check("w1_strobe_present", strobe_q.size() - base, 2);
    end

    // Random read back with repeated START.
    read_txn(1'b1, 8'h03, 2);
    check("rr_byte0", rd_q[0], 8'h5A);
    check("rr_byte1", rd_q[1], 8'hC3);

    // Wrong address: no ACK, SDA never driven until STOP.
    base = oe_count;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mismatch_nack", ack, I2C_NACK);
    check("mismatch_busy", busy, 1'b0);
    write_byte(8'h00, ack);
    check("mismatch_follow_nack", ack, I2C_NACK);
    check("mismatch_oe_quiet", oe_count - base, 0);
    i2c_stop();
    tx_q.delete(); tx_q.push_back(8'h77);
    write_txn(8'h08);

    // Pointer wrap at the top of memory.
    tx_q.delete(); tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    base = strobe_q.size();
    write_txn(8'h0F);
    if (strobe_q.size() >= base + 2) begin
      check("wrap_addr0", strobe_q[base].a, 4'd15);
      check("wrap_addr1", strobe_q[base+1].a, 4'd0);
    end
    read_txn(1'b1, 8'h0F, 2);
    check("wrap_rd0", rd_q[0], 8'h11);
    check("wrap_rd1", rd_q[1], 8'h22);

    // Upper word-address bits are ignored; a current-address read follows.
    tx_q.delete();
    write_txn(8'hF2);
    read_txn(1'b0, 8'h00, 1);
    check("upper_bits_ignored", rd_q[0], 8'h00);

    // Randomized write / read-back / current-address reads.
    for (int t = 0; t < 6; t++) begin
      logic [7:0] w;
      int         n;
      w = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      tx_q.delete();
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      write_txn(w);
      read_txn(1'b1, w, n);
      read_txn(1'b0, 8'h00, $urandom_range(1, 3));
    end

    // Reset while the target is driving the address ACK.
    addr_w = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
    m_low = 1'b0;
    check("rst_ack_driven", sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_ptr = 0;
    read_txn(1'b1, 8'h03, 2);
    check("rst_mem_cleared0", rd_q[0], 8'h00);
    check("rst_mem_cleared1", rd_q[1], 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
